// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad peripheral on the 16-bit I/O bus.
// Drives one column low at a time and samples the rows once per slot.
// Presses and releases are debounced over DEBOUNCE_CNT consecutive samples.
// The resulting 4-bit key code is latched for the CPU, and a data register
// read acknowledges it.
// Optional feature macro: KEYPAD_IRQ_EN adds a level irq output equal to valid.
module keypad_scanner #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        read_enable,
    input  logic        address,
    output logic [15:0] read_data_out,
    input  logic [3:0]  key_row,
    output logic [3:0]  key_col
`ifdef KEYPAD_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEBOUNCE_CNT + 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD} state_t;

    state_t        state, state_next;
    logic [3:0]    row_meta, rows;
    logic [SW-1:0] slot;
    logic          tick;
    logic [1:0]    col, col_next;
    logic [3:0]    pattern, pattern_next;
    logic [DW-1:0] dcnt, dcnt_next, rcnt, rcnt_next;
    logic          latch;
    logic [1:0]    row_idx;
    logic [3:0]    code;
    logic [3:0]    data_reg;
    logic          valid, overrun;
    logic          data_read;

    assign tick      = (slot == SW'(SCAN_DIV - 1));
    assign key_col   = ~(4'b0001 << col);
    assign code      = {row_idx, col};
    assign data_read = read_enable && !address;

`ifdef KEYPAD_IRQ_EN
    assign irq = valid;
`endif

    // Two-flop synchronizer for the asynchronous row inputs (idle = all high).
    always_ff @(posedge clock) begin
        if (reset) begin
            row_meta <= 4'hF;
            rows     <= 4'hF;
        end else begin
            row_meta <= key_row;
            rows     <= row_meta;
        end
    end

    // Slot counter: one sample tick every SCAN_DIV cycles.
    always_ff @(posedge clock) begin
        if (reset)     slot <= '0;
        else if (tick) slot <= '0;
        else           slot <= slot + SW'(1);
    end

    // Scan FSM state and counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= SCAN;
            col     <= 2'd0;
            pattern <= 4'hF;
            dcnt    <= '0;
            rcnt    <= '0;
        end else begin
            state   <= state_next;
            col     <= col_next;
            pattern <= pattern_next;
            dcnt    <= dcnt_next;
            rcnt    <= rcnt_next;
        end
    end

    // Next-state logic: act only on sample ticks.
    always_comb begin
        state_next   = state;
        col_next     = col;
        pattern_next = pattern;
        dcnt_next    = dcnt;
        rcnt_next    = rcnt;
        latch        = 1'b0;
        if (tick) begin
            case (state)
                SCAN: begin
                    if (rows != 4'hF) begin
                        pattern_next = rows;
                        dcnt_next    = DW'(1);
                        if (DEBOUNCE_CNT == 1) begin
                            latch      = 1'b1;
                            rcnt_next  = '0;
                            state_next = HOLD;
                        end else begin
                            state_next = DEBOUNCE;
                        end
                    end else begin
                        col_next = col + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (rows == pattern) begin
                        dcnt_next = dcnt + DW'(1);
                        if (dcnt_next == DW'(DEBOUNCE_CNT)) begin
                            latch      = 1'b1;
                            rcnt_next  = '0;
                            state_next = HOLD;
                        end
                    end else begin
                        col_next   = col + 2'd1;
                        state_next = SCAN;
                    end
                end
                HOLD: begin
                    if (rows == 4'hF) begin
                        rcnt_next = rcnt + DW'(1);
                        if (rcnt_next == DW'(DEBOUNCE_CNT)) begin
                            rcnt_next  = '0;
                            col_next   = col + 2'd1;
                            state_next = SCAN;
                        end
                    end else begin
                        rcnt_next = '0;
                    end
                end
                default: state_next = SCAN;
            endcase
        end
    end

    // Row index of the captured pattern: lowest-index low row wins.
    always_comb begin
        row_idx = 2'd0;
        if      (!pattern_next[0]) row_idx = 2'd0;
        else if (!pattern_next[1]) row_idx = 2'd1;
        else if (!pattern_next[2]) row_idx = 2'd2;
        else if (!pattern_next[3]) row_idx = 2'd3;
    end

    // Key latch: a data read clears valid/overrun, a same-cycle latch wins.
    always_ff @(posedge clock) begin
        if (reset) begin
            data_reg <= 4'h0;
            valid    <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (data_read) begin
                valid   <= 1'b0;
                overrun <= 1'b0;
            end
            if (latch) begin
                data_reg <= code;
                valid    <= 1'b1;
                overrun  <= data_read ? 1'b0 : (overrun | valid);
            end
        end
    end

    // Registered read port, returning pre-edge register contents.
    always_ff @(posedge clock) begin
        if (reset) begin
            read_data_out <= 16'h0000;
        end else if (read_enable) begin
            if (address) read_data_out <= {13'h0, state == HOLD, overrun, valid};
            else         read_data_out <= {12'h0, data_reg};
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized scoreboard bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_CNT=3).
// A physical keypad is modelled from the set of pressed keys and the column
// drive. A behavioural reference predicts column drive and register reads.
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DB = 3;
    localparam int M_SCAN = 0, M_DEB = 1, M_HOLD = 2;

    logic        clock = 0;
    logic        reset = 1;
    logic        read_enable = 0;
    logic        address = 0;
    logic [15:0] read_data_out;
    logic [3:0]  key_row;
    logic [3:0]  key_col;
`ifdef KEYPAD_IRQ_EN
    logic        irq;
`endif

    logic [15:0] pressed = 16'h0;

    int total = 0;
    int bad   = 0;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
        .clock(clock),
        .reset(reset),
        .read_enable(read_enable),
        .address(address),
        .read_data_out(read_data_out),
        .key_row(key_row),
        .key_col(key_col)
`ifdef KEYPAD_IRQ_EN
        ,
        .irq(irq)
`endif
    );

    always #5 clock = ~clock;

    // Physical keypad: key k = row*4 + col pulls its row low while its column is driven.
    function automatic logic [3:0] keypad(input logic [15:0] p, input logic [3:0] kc);
        logic [3:0] r;
        r = 4'hF;
        for (int k = 0; k < 16; k++)
            if (p[k] && !kc[k % 4]) r[k / 4] = 1'b0;
        return r;
    endfunction

    assign key_row = keypad(pressed, key_col);

    // Reference model state
    int         m_col, m_slot, m_mode, m_hits, m_rel, m_data;
    bit         m_valid, m_ovr;
    logic [3:0] m_s1, m_s2, m_pat;

    function automatic int key_code(input logic [3:0] pat, input int c);
        int r;
        r = 0;
        for (int i = 3; i >= 0; i--) if (!pat[i]) r = i;
        return r * 4 + c;
    endfunction

    function automatic logic [15:0] model_read(input bit a);
        int v;
        if (a) v = ((m_mode == M_HOLD) ? 4 : 0) + (m_ovr ? 2 : 0) + (m_valid ? 1 : 0);
        else   v = m_data;
        return 16'(v);
    endfunction

    task automatic model_step(input bit rst, input logic [3:0] rin, input bit rd, input bit a);
        bit latch, dread, was_valid;
        int code;
        latch = 0; code = 0;
        if (rst) begin
            m_col = 0; m_slot = 0; m_mode = M_SCAN; m_hits = 0; m_rel = 0;
            m_data = 0; m_valid = 0; m_ovr = 0;
            m_s1 = 4'hF; m_s2 = 4'hF; m_pat = 4'hF;
            return;
        end
        if (m_slot == SD - 1) begin
            if (m_mode == M_SCAN) begin
                if (m_s2 != 4'hF) begin
                    m_pat = m_s2; m_hits = 1;
                    if (m_hits == DB) begin latch = 1; m_mode = M_HOLD; m_rel = 0; end
                    else m_mode = M_DEB;
                end else m_col = (m_col + 1) % 4;
            end else if (m_mode == M_DEB) begin
                if (m_s2 == m_pat) begin
                    m_hits++;
                    if (m_hits == DB) begin latch = 1; m_mode = M_HOLD; m_rel = 0; end
                end else begin
                    m_mode = M_SCAN; m_col = (m_col + 1) % 4;
                end
            end else begin
                if (m_s2 == 4'hF) begin
                    m_rel++;
                    if (m_rel == DB) begin m_mode = M_SCAN; m_rel = 0; m_col = (m_col + 1) % 4; end
                end else m_rel = 0;
            end
            if (latch) code = key_code(m_pat, m_col);
        end
        dread = rd && !a;
        was_valid = m_valid;
        if (dread) begin m_valid = 0; m_ovr = 0; end
        if (latch) begin
            m_data  = code;
            m_ovr   = dread ? 1'b0 : (m_ovr | was_valid);
            m_valid = 1;
        end
        m_slot = (m_slot + 1) % SD;
        m_s2 = m_s1;
        m_s1 = rin;
    endtask

    // Scoreboard
    logic [15:0] exp_q[$];
    bit          addr_q[$];
    bit          rd_pend = 0;

    always @(posedge clock) rd_pend <= read_enable && !reset;

    // Monitor: compare each read response one cycle after its strobe.
    always @(negedge clock) begin
        if (rd_pend) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL read_underflow got %h with nothing expected", read_data_out);
            end else begin
                logic [15:0] e;
                bit          a;
                e = exp_q.pop_front();
                a = addr_q.pop_front();
                if (read_data_out !== e) begin
                    bad++;
                    $display("FAIL %s_read got %h exp %h at %0t", a ? "status" : "data", read_data_out, e, $time);
                end
            end
        end
    end

    // One clock cycle: drive at negedge, model the edge, return at next negedge.
    task automatic step(input bit rst, input bit rd, input bit a);
        logic [3:0] rin;
        reset = rst; read_enable = rd; address = a;
        if (rd && !rst) begin
            exp_q.push_back(model_read(a));
            addr_q.push_back(a);
        end
        rin = keypad(pressed, key_col);
        if (!rst) begin
            total++;
            if (key_col !== ~(4'b0001 << m_col)) begin
                bad++;
                $display("FAIL key_col got %b exp %b at %0t", key_col, ~(4'b0001 << m_col), $time);
            end
`ifdef KEYPAD_IRQ_EN
            total++;
            if (irq !== m_valid) begin
                bad++;
                $display("FAIL irq got %b exp %b", irq, m_valid);
            end
`endif
        end
        @(posedge clock);
        model_step(rst, rin, rd, a);
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0);
    endtask

    task automatic rd(input bit a);
        step(0, 1, a);
    endtask

    task automatic wait_mode(input int mode, input string what);
        int n;
        n = 0;
        while (m_mode != mode && n < 200) begin step(0, 0, 0); n++; end
        total++;
        if (m_mode != mode) begin
            bad++;
            $display("FAIL timeout_%s got mode %0d exp %0d", what, m_mode, mode);
        end
    endtask

    initial begin
        bit found;
        @(negedge clock);
        // Reset values while reset is held
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0);
            total += 2;
            if (key_col !== 4'b1110) begin bad++; $display("FAIL reset_key_col got %b exp 1110", key_col); end
            if (read_data_out !== 16'h0) begin bad++; $display("FAIL reset_rdata got %h exp 0000", read_data_out); end
        end
        // Idle column stepping
        idle(20);
        rd(1);

        // Clean press: key 9 (row 2, col 1)
        pressed = 16'h0200;
        wait_mode(M_HOLD, "press9");
        idle(2);
        rd(0); rd(1);
        pressed = 16'h0;
        wait_mode(M_SCAN, "release9");
        rd(1);

        // Bounce: key 4 (row 1, col 0) released right after detection
        pressed = 16'h0010;
        wait_mode(M_DEB, "bounce");
        pressed = 16'h0;
        idle(12);
        rd(1);

        // Overrun: key 0 then key 15 without reading
        pressed = 16'h0001; wait_mode(M_HOLD, "key0");
        pressed = 16'h0;    wait_mode(M_SCAN, "rel0");
        pressed = 16'h8000; wait_mode(M_HOLD, "key15");
        pressed = 16'h0;    wait_mode(M_SCAN, "rel15");
        rd(1); rd(0); rd(1);

        // Simultaneous latch and data read
        pressed = 16'h0020; wait_mode(M_HOLD, "key5");
        pressed = 16'h0;    wait_mode(M_SCAN, "rel5");
        pressed = 16'h0400;
        found = 0;
        for (int n = 0; n < 200 && !found; n++) begin
            if (m_mode == M_DEB && m_hits == DB - 1 && m_slot == SD - 1 && m_s2 == m_pat) begin
                rd(0); found = 1;
            end else step(0, 0, 0);
        end
        total++;
        if (!found) begin bad++; $display("FAIL timeout_simul got 0 exp 1"); end
        rd(1);
        pressed = 16'h0; wait_mode(M_SCAN, "rel10");
        rd(0);

        // Reset during debounce
        pressed = 16'h1000;
        wait_mode(M_DEB, "deb_reset");
        step(1, 0, 0);
        total += 2;
        if (key_col !== 4'b1110) begin bad++; $display("FAIL midreset_key_col got %b exp 1110", key_col); end
        if (read_data_out !== 16'h0) begin bad++; $display("FAIL midreset_rdata got %h exp 0000", read_data_out); end
`ifdef KEYPAD_IRQ_EN
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL midreset_irq got %b exp 0", irq); end
`endif
        pressed = 16'h0;
        rd(1);
        idle(20);

        // Randomized traffic: presses of 1-2 keys, random reads, occasional reset
        for (int it = 0; it < 100; it++) begin
            int hold, gap;
            pressed = 16'h0;
            pressed[$urandom_range(15, 0)] = 1'b1;
            if ($urandom_range(3, 0) == 0) pressed[$urandom_range(15, 0)] = 1'b1;
            hold = $urandom_range(60, 1);
            for (int c = 0; c < hold; c++) begin
                if ($urandom_range(4, 0) == 0) rd(1'($urandom_range(1, 0)));
                else step(($urandom_range(199, 0) == 0), 0, 0);
            end
            pressed = 16'h0;
            gap = $urandom_range(50, 0);
            for (int c = 0; c < gap; c++) begin
                if ($urandom_range(4, 0) == 0) rd(1'($urandom_range(1, 0)));
                else step(0, 0, 0);
            end
        end
        rd(1); rd(0);
        idle(3);
        #1;
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL pending_reads got %0d exp 0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
